ahb_sram_subordinate: RTL and testbench

AHB-lite subordinate backed by an internal word-organised SRAM. It is the device under test that the subordinate assertion checker monitors. It accepts pipelined single and burst transfers from the manager, inserts a programmable number of wait states per data phase, and returns two-cycle ERROR responses for illegal accesses.

---
 rtl/ahb_sram_subordinate_if.sv | 37 +++
 rtl/ahb_sram_subordinate.sv | 221 ++++++++++++++++++++++
 tb/tb_ahb_sram_subordinate.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_sram_subordinate_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ahb_sram_subordinate_if                                      |
// | Description : AHB-lite bus bundle between a manager and the SRAM           |
// |               subordinate. Address/control/write data flow manager to      |
// |               subordinate; read data, response and HREADY flow back.       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface ahb_sram_subordinate_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HRESP;
    logic                  HREADY;

    // Manager side: drives the address phase and write data.
    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        input  HRDATA, HRESP, HREADY
    );

    // Subordinate side: samples the address phase, returns data/response.
    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        output HRDATA, HRESP, HREADY
    );
endinterface
`default_nettype wire

// File: rtl/ahb_sram_subordinate.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ahb_sram_subordinate                                         |
// | Description : AHB-lite subordinate backed by a word-organised SRAM.        |
// |               Pipelined single/burst transfers, WAIT_STATES wait cycles    |
// |               per data phase, two-cycle ERROR response for out-of-range,   |
// |               misaligned or over-wide accesses, and read-after-write       |
// |               forwarding so an overlapping read never stalls.              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module ahb_sram_subordinate #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input  wire logic              clk,
    input  wire logic              HRESETn,
    ahb_sram_subordinate_if.slave  bus
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_BYTES = DATA_WIDTH / 8;
    localparam int c_OFS_W = $clog2(c_BYTES);
    localparam int c_IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // First byte address past the end of the array; anything at or above errors.
    localparam logic [ADDR_WIDTH:0] c_MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_DEPTH * c_BYTES);

    // Largest legal HSIZE is the full data bus width.
    localparam logic [2:0] c_MAX_SIZE = 3'(c_OFS_W);

    // Wait counter reload: counts the remaining WAIT cycles after the first.
    localparam logic [2:0] c_WS_M1 = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_WAIT = 3'd1;
    localparam logic [2:0] c_ST_LAST = 3'd2;
    localparam logic [2:0] c_ST_ERR1 = 3'd3;
    localparam logic [2:0] c_ST_ERR2 = 3'd4;

    // ------------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic [2:0]            r_state;
    logic [2:0]            r_wait_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [2:0]            r_size;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic [2:0]            w_state_nxt;
    logic [2:0]            w_wait_cnt_nxt;
    logic                  w_hready;
    logic                  w_accept;
    logic                  w_oob;
    logic [ADDR_WIDTH-1:0] w_align_mask;
    logic                  w_misaligned;
    logic                  w_too_wide;
    logic                  w_err;

    logic                  w_wr_en;
    logic [c_IDX_W-1:0]    w_wr_idx;
    logic [c_BYTES-1:0]    w_lane_en;
    int                    w_ofs;
    int                    w_nbytes;

    logic                  w_from_wait;
    logic                  w_rd_load;
    logic [c_IDX_W-1:0]    w_rd_idx;
    logic [DATA_WIDTH-1:0] w_rd_word;

    logic                  w_unused;

    // ------------------------------------------------------------------------
    // Address-phase decode
    // ------------------------------------------------------------------------
    // The bus HREADY is our own: a new address is only sampled when we are ready.
    assign w_hready = (r_state != c_ST_WAIT) && (r_state != c_ST_ERR1);
    assign w_accept = w_hready & bus.HSEL & bus.HTRANS[1];

    assign w_oob        = ({1'b0, bus.HADDR} >= c_MEM_BYTES);
    assign w_align_mask = (ADDR_WIDTH'(1) << bus.HSIZE) - ADDR_WIDTH'(1);
    assign w_misaligned = |(bus.HADDR & w_align_mask);
    assign w_too_wide   = (bus.HSIZE > c_MAX_SIZE);
    assign w_err        = w_oob | w_misaligned | w_too_wide;

    // ------------------------------------------------------------------------
    // Next-state logic: IDLE, LAST and ERR2 all accept a new address phase
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            c_ST_IDLE, c_ST_LAST, c_ST_ERR2: begin
                if (w_accept) begin
                    if (w_err) begin
                        w_state_nxt = c_ST_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        w_state_nxt = c_ST_LAST;
                    end else begin
                        w_state_nxt    = c_ST_WAIT;
                        w_wait_cnt_nxt = c_WS_M1;
                    end
                end else begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_WAIT: begin
                if (r_wait_cnt == 3'd0) begin
                    w_state_nxt = c_ST_LAST;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - 3'd1;
                end
            end
            c_ST_ERR1: begin
                w_state_nxt = c_ST_ERR2;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // State, wait counter and registered address-phase fields.
    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state    <= c_ST_IDLE;
            r_wait_cnt <= 3'd0;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_size     <= 3'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_accept) begin
                r_addr  <= bus.HADDR;
                r_write <= bus.HWRITE;
                r_size  <= bus.HSIZE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Write path: commit byte lanes at the end of a write LAST cycle
    // ------------------------------------------------------------------------
    // LAST is only reachable for legal transfers, so errored writes never commit.
    assign w_wr_en  = (r_state == c_ST_LAST) && r_write;
    assign w_wr_idx = r_addr[c_OFS_W +: c_IDX_W];
    assign w_ofs    = int'(r_addr[c_OFS_W-1:0]);
    assign w_nbytes = 1 << r_size;

    // Little-endian lane mask covering [offset, offset + 2^size).
    always_comb begin
        w_lane_en = '0;
        for (int i = 0; i < c_BYTES; i++) begin
            if ((i >= w_ofs) && (i < (w_ofs + w_nbytes))) begin
                w_lane_en[i] = 1'b1;
            end
        end
    end

    // Memory array is deliberately not reset; only selected lanes are written.
    always_ff @(posedge clk) begin
        if (w_wr_en && HRESETn) begin
            for (int i = 0; i < c_BYTES; i++) begin
                if (w_lane_en[i]) begin
                    r_mem[w_wr_idx][8*i +: 8] <= bus.HWDATA[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read path: HRDATA is loaded on the edge that enters a read LAST cycle
    // ------------------------------------------------------------------------
    // Entering LAST from WAIT uses the registered address; entering directly
    // from an accept (no wait states) uses the live address phase.
    assign w_from_wait = (r_state == c_ST_WAIT);
    assign w_rd_load   = (w_state_nxt == c_ST_LAST) &&
                         (w_from_wait ? !r_write : !bus.HWRITE);
    assign w_rd_idx    = w_from_wait ? r_addr[c_OFS_W +: c_IDX_W]
                                     : bus.HADDR[c_OFS_W +: c_IDX_W];

    // Memory word with any lanes being committed on this same edge forwarded.
    always_comb begin
        w_rd_word = r_mem[w_rd_idx];
        if (w_wr_en && (w_wr_idx == w_rd_idx)) begin
            for (int i = 0; i < c_BYTES; i++) begin
                if (w_lane_en[i]) begin
                    w_rd_word[8*i +: 8] = bus.HWDATA[8*i +: 8];
                end
            end
        end
    end

    // Read data register; holds its value outside read LAST cycles.
    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            r_rdata <= '0;
        end else if (w_rd_load) begin
            r_rdata <= w_rd_word;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.HREADY = w_hready;
    assign bus.HRESP  = (r_state == c_ST_ERR1) || (r_state == c_ST_ERR2);
    assign bus.HRDATA = r_rdata;

    // Burst type, protection, HTRANS[0] and high address bits carry no function here.
    assign w_unused = ^{bus.HBURST, bus.HPROT, bus.HTRANS, r_addr};

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_subordinate.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ahb_sram_subordinate                                      |
// | Description : Directed self-checking bench for ahb_sram_subordinate.       |
// |               Two instances share one stimulus bus: WAIT_STATES=1 and      |
// |               WAIT_STATES=0; tgt selects which one is addressed.           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_ahb_sram_subordinate;

    logic clk = 1'b0;
    logic HRESETn = 1'b0;
    always #5 clk = ~clk;

    // 1 addresses the one-wait-state instance, 0 the zero-wait-state one.
    logic        tgt = 1'b1;
    logic        tb_hsel = 1'b0;
    logic [31:0] tb_haddr = '0;
    logic [1:0]  tb_htrans = 2'b00;
    logic        tb_hwrite = 1'b0;
    logic [2:0]  tb_hsize = 3'd2;
    logic [2:0]  tb_hburst = 3'd0;
    logic [3:0]  tb_hprot = 4'h3;
    logic [31:0] tb_hwdata = '0;

    ahb_sram_subordinate_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) u_if1 ();
    ahb_sram_subordinate_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) u_if0 ();

    assign u_if1.HSEL   = tb_hsel & tgt;
    assign u_if1.HADDR  = tb_haddr;
    assign u_if1.HTRANS = tb_htrans;
    assign u_if1.HWRITE = tb_hwrite;
    assign u_if1.HSIZE  = tb_hsize;
    assign u_if1.HBURST = tb_hburst;
    assign u_if1.HPROT  = tb_hprot;
    assign u_if1.HWDATA = tb_hwdata;

    assign u_if0.HSEL   = tb_hsel & ~tgt;
    assign u_if0.HADDR  = tb_haddr;
    assign u_if0.HTRANS = tb_htrans;
    assign u_if0.HWRITE = tb_hwrite;
    assign u_if0.HSIZE  = tb_hsize;
    assign u_if0.HBURST = tb_hburst;
    assign u_if0.HPROT  = tb_hprot;
    assign u_if0.HWDATA = tb_hwdata;

    ahb_sram_subordinate #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(1)
    ) u_dut_ws1 (
        .clk(clk), .HRESETn(HRESETn), .bus(u_if1)
    );

    ahb_sram_subordinate #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)
    ) u_dut_ws0 (
        .clk(clk), .HRESETn(HRESETn), .bus(u_if0)
    );

    logic        obs_hready;
    logic        obs_hresp;
    logic [31:0] obs_hrdata;
    assign obs_hready = tgt ? u_if1.HREADY : u_if0.HREADY;
    assign obs_hresp  = tgt ? u_if1.HRESP  : u_if0.HRESP;
    assign obs_hrdata = tgt ? u_if1.HRDATA : u_if0.HRDATA;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Byte-level reference memory per instance; mknown marks bytes ever written.
    logic [7:0] mdl    [2][1024];
    bit         mknown [2][1024];

    typedef struct {
        logic [31:0] data;
        logic [31:0] mask;
    } exp_t;
    exp_t sb_q[$];

    task automatic chkm(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp, input logic [31:0] mask);
        n_checks++;
        assert ((obs & mask) === (exp & mask)) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs & mask, exp & mask);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chkm(tag, obs, exp, 32'hFFFF_FFFF);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void mdl_write(input int t, input logic [31:0] addr,
                                      input logic [2:0] size, input logic [31:0] wdata);
        for (int i = 0; i < (1 << size); i++) begin
            int a;
            int lane;
            a    = int'(addr) + i;
            lane = a % 4;
            mdl[t][a]    = wdata[8*lane +: 8];
            mknown[t][a] = 1'b1;
        end
    endfunction

    // Expected full word for a read, masked to bytes with known contents.
    function automatic void sb_push(input int t, input logic [31:0] addr);
        exp_t e;
        int   base;
        e.data = '0;
        e.mask = '0;
        base   = int'(addr) & ~3;
        for (int j = 0; j < 4; j++) begin
            e.data[8*j +: 8] = mdl[t][base + j];
            e.mask[8*j +: 8] = mknown[t][base + j] ? 8'hFF : 8'h00;
        end
        sb_q.push_back(e);
    endfunction

    task automatic sb_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard required pending read", tag);
        end else begin
            e = sb_q.pop_front();
            chkm(tag, obs_hrdata, e.data, e.mask);
        end
    endtask

    // One non-pipelined transfer: address phase, data phase(s), back to IDLE.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input logic exp_err, input string tag);
        int ws;
        int t;
        ws = tgt ? 1 : 0;
        t  = tgt ? 1 : 0;
        chk({tag, " addr rdy"}, 32'(obs_hready), 32'd1);
        tb_hsel   = 1'b1;
        tb_htrans = 2'b10;
        tb_hwrite = wr;
        tb_haddr  = addr;
        tb_hsize  = size;
        tb_hburst = 3'd0;
        if (!exp_err) begin
            if (wr) mdl_write(t, addr, size, wdata);
            else    sb_push(t, addr);
        end
        step();
        tb_hsel   = 1'b0;
        tb_htrans = 2'b00;
        tb_hwdata = wdata;
        if (exp_err) begin
            chk({tag, " err1 rdy"},  32'(obs_hready), 32'd0);
            chk({tag, " err1 resp"}, 32'(obs_hresp),  32'd1);
            step();
            chk({tag, " err2 rdy"},  32'(obs_hready), 32'd1);
            chk({tag, " err2 resp"}, 32'(obs_hresp),  32'd1);
            step();
            chk({tag, " post-err rdy"},  32'(obs_hready), 32'd1);
            chk({tag, " post-err resp"}, 32'(obs_hresp),  32'd0);
        end else begin
            for (int k = 0; k < ws; k++) begin
                chk({tag, " wait rdy"},  32'(obs_hready), 32'd0);
                chk({tag, " wait resp"}, 32'(obs_hresp),  32'd0);
                step();
            end
            chk({tag, " last rdy"},  32'(obs_hready), 32'd1);
            chk({tag, " last resp"}, 32'(obs_hresp),  32'd0);
            if (!wr) sb_check({tag, " rdata"});
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "timeout");
    end

    initial begin
        // ---------------- reset state ----------------
        #2;
        chk("rst ws1 rdy",   32'(u_if1.HREADY), 32'd1);
        chk("rst ws1 resp",  32'(u_if1.HRESP),  32'd0);
        chk("rst ws1 rdata", u_if1.HRDATA,      32'd0);
        chk("rst ws0 rdy",   32'(u_if0.HREADY), 32'd1);
        chk("rst ws0 resp",  32'(u_if0.HRESP),  32'd0);
        chk("rst ws0 rdata", u_if0.HRDATA,      32'd0);
        step();
        step();
        HRESETn = 1'b1;
        step();

        // ---------------- one wait state instance ----------------
        tgt = 1'b1;
        xfer(1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF, 1'b0, "t1 wr");
        xfer(1'b0, 32'h10, 3'd2, 32'h0,         1'b0, "t1 rd");

        xfer(1'b1, 32'h20, 3'd2, 32'h1122_3344, 1'b0, "t2 init");
        xfer(1'b1, 32'h21, 3'd0, 32'h0000_AA00, 1'b0, "t2 byte");
        xfer(1'b1, 32'h22, 3'd1, 32'h5566_0000, 1'b0, "t2 half");
        xfer(1'b0, 32'h20, 3'd2, 32'h0,         1'b0, "t2 rd");

        xfer(1'b1, 32'h00, 3'd2, 32'hA5A5_0001, 1'b0, "t3 init");
        xfer(1'b1, 32'h02, 3'd2, 32'hFFFF_FFFF, 1'b1, "t3 misalign");
        xfer(1'b0, 32'h00, 3'd2, 32'h0,         1'b0, "t3 rd");

        xfer(1'b0, 32'h400, 3'd2, 32'h0,         1'b1, "t4 oob");
        xfer(1'b1, 32'h3FC, 3'd2, 32'h0BAD_F00D, 1'b0, "t4 top wr");
        xfer(1'b0, 32'h3FC, 3'd2, 32'h0,         1'b0, "t4 top rd");
        xfer(1'b0, 32'h08,  3'd3, 32'h0,         1'b1, "t4 wide");

        // BUSY with HSEL is not a transfer: zero wait, OKAY.
        tb_hsel   = 1'b1;
        tb_htrans = 2'b01;
        tb_haddr  = 32'h10;
        step();
        chk("busy rdy",  32'(obs_hready), 32'd1);
        chk("busy resp", 32'(obs_hresp),  32'd0);
        tb_hsel   = 1'b0;
        tb_htrans = 2'b00;
        step();

        // ---------------- reset during a write's wait cycle ----------------
        xfer(1'b1, 32'h80, 3'd2, 32'hCAFE_F00D, 1'b0, "t6 init");
        tb_hsel   = 1'b1;
        tb_htrans = 2'b10;
        tb_hwrite = 1'b1;
        tb_haddr  = 32'h80;
        tb_hsize  = 3'd2;
        step();
        tb_hsel   = 1'b0;
        tb_htrans = 2'b00;
        tb_hwdata = 32'h1234_5678;
        chk("t6 wait rdy", 32'(obs_hready), 32'd0);
        HRESETn = 1'b0;
        #1;
        chk("t6 rst rdy",   32'(obs_hready), 32'd1);
        chk("t6 rst resp",  32'(obs_hresp),  32'd0);
        chk("t6 rst rdata", obs_hrdata,      32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        HRESETn = 1'b1;
        step();
        xfer(1'b0, 32'h80, 3'd2, 32'h0, 1'b0, "t6 rd");

        // ---------------- zero wait state instance: INCR4 + forwarding ----------------
        tgt = 1'b0;
        #1;
        chk("t5 start rdy", 32'(obs_hready), 32'd1);
        tb_hsel   = 1'b1;
        tb_htrans = 2'b10;
        tb_hwrite = 1'b1;
        tb_hsize  = 3'd2;
        tb_hburst = 3'b011;
        tb_haddr  = 32'h40;
        mdl_write(0, 32'h40, 3'd2, 32'd1);
        for (int b = 1; b < 4; b++) begin
            step();
            chk("t5 beat rdy", 32'(obs_hready), 32'd1);
            tb_hwdata = 32'(b);
            tb_htrans = 2'b11;
            tb_haddr  = 32'h40 + 32'(4 * b);
            mdl_write(0, tb_haddr, 3'd2, 32'(b + 1));
        end
        step();
        chk("t5 beat rdy", 32'(obs_hready), 32'd1);
        tb_hwdata = 32'd4;
        tb_htrans = 2'b10;
        tb_hwrite = 1'b0;
        tb_hburst = 3'd0;
        tb_haddr  = 32'h4C;
        sb_push(0, 32'h4C);
        step();
        chk("t5 rd rdy",  32'(obs_hready), 32'd1);
        chk("t5 rd resp", 32'(obs_hresp),  32'd0);
        sb_check("t5 fwd rdata");
        tb_hsel   = 1'b0;
        tb_htrans = 2'b00;
        step();
        chk("t5 idle rdy", 32'(obs_hready), 32'd1);
        xfer(1'b0, 32'h40, 3'd2, 32'h0, 1'b0, "t5 rd first");
        xfer(1'b0, 32'h48, 3'd2, 32'h0, 1'b0, "t5 rd third");

        chk("sb drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
